// File: rtl/rf_write_sequencer_if.sv
// Writeback request bundle: ALU and load producers with valid/ready
// handshakes feeding the register-file write sequencer.
interface rf_write_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    modport master (
        output alu_valid, alu_reg, alu_data,
        input  alu_ready,
        output mem_valid, mem_reg, mem_data,
        input  mem_ready
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        output alu_ready,
        input  mem_valid, mem_reg, mem_data,
        output mem_ready
    );
endinterface

// File: rtl/rf_write_sequencer.sv
// Register-file write front end: arbitrates ALU/load writebacks into an
// in-order FIFO, retires one write per cycle, and exposes pending writes.
module rf_write_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    rf_write_sequencer_if.slave    req,
    input  logic                   rf_stall,
    output logic [ADDR_W-1:0]      WriteReg,
    output logic [DATA_W-1:0]      WriteData,
    output logic                   RegWrite,
    input  logic [ADDR_W-1:0]      pend_reg,
    output logic                   pend_hit,
    output logic [DATA_W-1:0]      pend_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] regMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  idx;
    logic              memFire;
    logic              aluFire;
    logic              doPush;
    logic              doPop;
    logic [ADDR_W-1:0] pushReg;
    logic [DATA_W-1:0] pushData;

    assign full  = count == CNT_W'(DEPTH);
    assign empty = count == '0;

    // Loads win over ALU results; readiness depends only on pre-edge occupancy.
    assign req.mem_ready = !full;
    assign req.alu_ready = !full && !req.mem_valid;

    assign memFire  = req.mem_valid && !full;
    assign aluFire  = req.alu_valid && !full && !req.mem_valid;
    assign pushReg  = memFire ? req.mem_reg : req.alu_reg;
    assign pushData = memFire ? req.mem_data : req.alu_data;

    // Writes to $0 complete the handshake but are dropped here.
    assign doPush = (memFire || aluFire) && pushReg != '0;
    assign doPop  = !empty && !rf_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            WriteReg  <= '0;
            WriteData <= '0;
            RegWrite  <= 1'b0;
        end else begin
            RegWrite <= doPop;
            if (doPop) begin
                WriteReg  <= regMem[head];
                WriteData <= dataMem[head];
                head      <= head + PTR_W'(1);
            end
            if (doPush) begin
                tail <= tail + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            regMem[tail]  <= pushReg;
            dataMem[tail] <= pushData;
        end
    end

    // Scan oldest to youngest so the youngest match overrides earlier ones.
    always_comb begin
        pend_hit  = 1'b0;
        pend_data = '0;
        idx       = head;
        if (RegWrite && WriteReg == pend_reg) begin
            pend_hit  = 1'b1;
            pend_data = WriteData;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count && regMem[idx] == pend_reg) begin
                pend_hit  = 1'b1;
                pend_data = dataMem[idx];
            end
        end
        if (pend_reg == '0) begin
            pend_hit  = 1'b0;
            pend_data = '0;
        end
    end
endmodule

// File: tb/tb_rf_write_sequencer.sv
// Self-checking bench for rf_write_sequencer: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_rf_write_sequencer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              rfStall;
    logic [ADDR_W-1:0] wReg;
    logic [DATA_W-1:0] wData;
    logic              regWrite;
    logic [ADDR_W-1:0] pendReg;
    logic              pendHit;
    logic [DATA_W-1:0] pendData;
    logic [2:0]        count;
    logic              full;
    logic              empty;

    int checks = 0;
    int errors = 0;

    wr_t               q[$];
    logic              expRW;
    logic [ADDR_W-1:0] expWReg;
    logic [DATA_W-1:0] expWData;

    always #5 clk = ~clk;

    rf_write_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_write_sequencer #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (bus),
        .rf_stall (rfStall),
        .WriteReg (wReg),
        .WriteData(wData),
        .RegWrite (regWrite),
        .pend_reg (pendReg),
        .pend_hit (pendHit),
        .pend_data(pendData),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_reg   = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_reg   = '0;
        bus.mem_data  = '0;
    endtask

    task automatic modelReset();
        q.delete();
        expRW    = 1'b0;
        expWReg  = '0;
        expWData = '0;
    endtask

    function automatic void pendModel(input logic [ADDR_W-1:0] r,
                                      output logic hit,
                                      output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (r != 0) begin
            if (expRW && expWReg == r) begin
                hit = 1'b1;
                d   = expWData;
            end
            foreach (q[i]) begin
                if (q[i].r == r) begin
                    hit = 1'b1;
                    d   = q[i].d;
                end
            end
        end
    endfunction

    // Advance one clock edge and update the model from pre-edge inputs.
    task automatic tick();
        wr_t               e;
        bit                memAcc;
        bit                aluAcc;
        bit                pop;
        logic [ADDR_W-1:0] pr;
        logic [DATA_W-1:0] pd;
        memAcc = bus.mem_valid && q.size() < DEPTH;
        aluAcc = bus.alu_valid && q.size() < DEPTH && !bus.mem_valid;
        pop    = q.size() > 0 && !rfStall;
        pr     = memAcc ? bus.mem_reg : bus.alu_reg;
        pd     = memAcc ? bus.mem_data : bus.alu_data;
        @(posedge clk);
        #1;
        expRW = pop;
        if (pop) begin
            e        = q.pop_front();
            expWReg  = e.r;
            expWData = e.d;
        end
        if ((memAcc || aluAcc) && pr != 0) begin
            e.r = pr;
            e.d = pd;
            q.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        rfStall = 1'b0;
        pendReg = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (regWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_regwrite got %b want 0", regWrite);
        end
        checks++;
        if (wReg !== '0 || wData !== '0) begin
            errors++;
            $display("FAIL reset_outregs got %0d/%0h want 0/0", wReg, wData);
        end
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got c=%0d e=%b f=%b want 0/1/0",
                     count, empty, full);
        end
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_single();
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd3;
        bus.alu_data  = 32'd10;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready got %b want 1", bus.alu_ready);
        end
        tick();
        idle();
        checks++;
        if (regWrite !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_queued got rw=%b c=%0d want 0/1",
                     regWrite, count);
        end
        tick();
        checks++;
        if (regWrite !== 1'b1 || wReg !== 5'd3 || wData !== 32'd10) begin
            errors++;
            $display("FAIL single_write got rw=%b r=%0d d=%0d want 1/3/10",
                     regWrite, wReg, wData);
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL single_count got %0d want 0", count);
        end
        tick();
        checks++;
        if (regWrite !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse got %b want 0", regWrite);
        end
    endtask

    task automatic test_zero_reg();
        bus.mem_valid = 1'b1;
        bus.mem_reg   = 5'd1;
        bus.mem_data  = 32'd11;
        #1;
        checks++;
        if (bus.mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_memready got %b want 1", bus.mem_ready);
        end
        tick();
        idle();
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd0;
        bus.alu_data  = 32'd10;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_aluready got %b want 1", bus.alu_ready);
        end
        tick();
        idle();
        checks++;
        if (regWrite !== 1'b1 || wReg !== 5'd1 || wData !== 32'd11) begin
            errors++;
            $display("FAIL zero_write1 got rw=%b r=%0d d=%0d want 1/1/11",
                     regWrite, wReg, wData);
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL zero_count got %0d want 0", count);
        end
        tick();
        checks++;
        if (regWrite !== 1'b0) begin
            errors++;
            $display("FAIL zero_nowrite got %b want 0", regWrite);
        end
    endtask

    task automatic test_priority();
        bus.mem_valid = 1'b1;
        bus.mem_reg   = 5'd5;
        bus.mem_data  = 32'h55;
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd6;
        bus.alu_data  = 32'h66;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_ready got alu=%b mem=%b want 0/1",
                     bus.alu_ready, bus.mem_ready);
        end
        tick();
        bus.mem_valid = 1'b0;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_aluready got %b want 1", bus.alu_ready);
        end
        tick();
        idle();
        checks++;
        if (regWrite !== 1'b1 || wReg !== 5'd5 || wData !== 32'h55) begin
            errors++;
            $display("FAIL prio_first got rw=%b r=%0d want 1/5",
                     regWrite, wReg);
        end
        tick();
        checks++;
        if (regWrite !== 1'b1 || wReg !== 5'd6 || wData !== 32'h66) begin
            errors++;
            $display("FAIL prio_second got rw=%b r=%0d want 1/6",
                     regWrite, wReg);
        end
        tick();
    endtask

    task automatic test_full_stall();
        for (int rnd = 0; rnd < 2; rnd++) begin
            rfStall = 1'b1;
            for (int k = 0; k < 5; k++) begin
                bus.alu_valid = 1'b1;
                bus.alu_reg   = 5'(8 + k);
                bus.alu_data  = 32'(rnd * 100 + k);
                #1;
                if (k < 4) begin
                    checks++;
                    if (bus.alu_ready !== 1'b1 || full !== 1'b0) begin
                        errors++;
                        $display("FAIL full_accept%0d got rdy=%b f=%b want 1/0",
                                 k, bus.alu_ready, full);
                    end
                    tick();
                end
            end
            checks++;
            if (full !== 1'b1 || bus.alu_ready !== 1'b0 ||
                bus.mem_ready !== 1'b0 || regWrite !== 1'b0) begin
                errors++;
                $display("FAIL full_flags got f=%b a=%b m=%b rw=%b want 1/0/0/0",
                         full, bus.alu_ready, bus.mem_ready, regWrite);
            end
            rfStall = 1'b0;
            #1;
            checks++;
            if (bus.alu_ready !== 1'b0) begin
                errors++;
                $display("FAIL full_noearly got %b want 0", bus.alu_ready);
            end
            for (int k = 0; k < 5; k++) begin
                tick();
                if (k == 1) idle();
                checks++;
                if (regWrite !== 1'b1 || wReg !== 5'(8 + k) ||
                    wData !== 32'(rnd * 100 + k)) begin
                    errors++;
                    $display("FAIL full_order%0d got rw=%b r=%0d d=%0d want 1/%0d/%0d",
                             k, regWrite, wReg, wData, 8 + k, rnd * 100 + k);
                end
            end
            tick();
            checks++;
            if (regWrite !== 1'b0 || count !== 3'd0) begin
                errors++;
                $display("FAIL full_drain got rw=%b c=%0d want 0/0",
                         regWrite, count);
            end
        end
    endtask

    task automatic test_pending();
        rfStall       = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd7;
        bus.alu_data  = 32'hA;
        tick();
        bus.alu_data = 32'hB;
        tick();
        idle();
        pendReg = 5'd7;
        #1;
        checks++;
        if (pendHit !== 1'b1 || pendData !== 32'hB) begin
            errors++;
            $display("FAIL pend_youngest got h=%b d=%0h want 1/b",
                     pendHit, pendData);
        end
        pendReg = 5'd0;
        #1;
        checks++;
        if (pendHit !== 1'b0 || pendData !== '0) begin
            errors++;
            $display("FAIL pend_zero got h=%b d=%0h want 0/0",
                     pendHit, pendData);
        end
        pendReg = 5'd7;
        rfStall = 1'b0;
        tick();
        checks++;
        if (regWrite !== 1'b1 || wData !== 32'hA || pendData !== 32'hB) begin
            errors++;
            $display("FAIL pend_fifo_over_out got rw=%b wd=%0h pd=%0h want 1/a/b",
                     regWrite, wData, pendData);
        end
        tick();
        checks++;
        if (pendHit !== 1'b1 || pendData !== 32'hB) begin
            errors++;
            $display("FAIL pend_outreg got h=%b d=%0h want 1/b",
                     pendHit, pendData);
        end
        tick();
        checks++;
        if (pendHit !== 1'b0) begin
            errors++;
            $display("FAIL pend_retired got h=%b want 0", pendHit);
        end
        pendReg = '0;
    endtask

    task automatic test_async_reset();
        rfStall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            bus.alu_valid = 1'b1;
            bus.alu_reg   = 5'(k);
            bus.alu_data  = 32'(k * 7);
            tick();
        end
        idle();
        rfStall = 1'b0;
        tick();
        checks++;
        if (regWrite !== 1'b1 || count !== 3'd2) begin
            errors++;
            $display("FAIL arst_pre got rw=%b c=%0d want 1/2", regWrite, count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (regWrite !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL arst_drop got rw=%b c=%0d e=%b want 0/0/1",
                     regWrite, count, empty);
        end
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (regWrite !== 1'b0 || count !== 3'd0) begin
                errors++;
                $display("FAIL arst_after%0d got rw=%b c=%0d want 0/0",
                         k, regWrite, count);
            end
        end
    endtask

    task automatic test_random();
        logic              eHit;
        logic [DATA_W-1:0] eData;
        for (int n = 0; n < 400; n++) begin
            bus.mem_valid = ($urandom % 100) < 35;
            bus.mem_reg   = 5'($urandom_range(0, 7));
            bus.mem_data  = $urandom;
            bus.alu_valid = ($urandom % 100) < 55;
            bus.alu_reg   = 5'($urandom_range(0, 7));
            bus.alu_data  = $urandom;
            rfStall       = ($urandom % 100) < 40;
            pendReg       = 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (count !== 3'(q.size()) || full !== (q.size() == DEPTH) ||
                empty !== (q.size() == 0)) begin
                errors++;
                $display("FAIL rnd_occ[%0d] got c=%0d f=%b e=%b want c=%0d",
                         n, count, full, empty, q.size());
            end
            checks++;
            if (bus.mem_ready !== (q.size() < DEPTH) ||
                bus.alu_ready !== (q.size() < DEPTH && !bus.mem_valid)) begin
                errors++;
                $display("FAIL rnd_ready[%0d] got m=%b a=%b qsize=%0d",
                         n, bus.mem_ready, bus.alu_ready, q.size());
            end
            pendModel(pendReg, eHit, eData);
            checks++;
            if (pendHit !== eHit || pendData !== eData) begin
                errors++;
                $display("FAIL rnd_pend[%0d] got h=%b d=%0h want h=%b d=%0h",
                         n, pendHit, pendData, eHit, eData);
            end
            tick();
            checks++;
            if (regWrite !== expRW || wReg !== expWReg || wData !== expWData) begin
                errors++;
                $display("FAIL rnd_out[%0d] got rw=%b r=%0d d=%0h want %b/%0d/%0h",
                         n, regWrite, wReg, wData, expRW, expWReg, expWData);
            end
        end
        idle();
        rfStall = 1'b0;
    endtask

    initial begin
        modelReset();
        test_reset();
        test_single();
        test_zero_reg();
        test_priority();
        test_full_stall();
        test_pending();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
